// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - Hack instruction field positions and ALU function type
package hack_pkg;

    localparam int BIT_C    = 15;
    localparam int BIT_A    = 12;
    localparam int COMP_LSB = 6;
    localparam int COMP_W   = 6;
    localparam int DEST_A   = 5;
    localparam int DEST_D   = 4;
    localparam int DEST_M   = 3;
    localparam int JMP_LT   = 2;
    localparam int JMP_EQ   = 1;
    localparam int JMP_GT   = 0;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_fn_t;

endpackage

// File: rtl/hack_cpu_wide_alu.sv
// rtl/hack_cpu_wide_alu.sv - Hack ALU (zx/nx/zy/ny/f/no) with zero flag
module hack_cpu_wide_alu
    import hack_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  alu_fn_t     fn,
    output logic [15:0] out,
    output logic        zero
);

    logic [15:0] w_x0, w_x1, w_y0, w_y1, w_f;

    always_comb begin
        w_x0 = fn.zx ? 16'h0000 : x;
        w_x1 = fn.nx ? ~w_x0 : w_x0;
        w_y0 = fn.zy ? 16'h0000 : y;
        w_y1 = fn.ny ? ~w_y0 : w_y0;
        w_f  = fn.f ? (w_x1 + w_y1) : (w_x1 & w_y1);
        out  = fn.no ? ~w_f : w_f;
        zero = (out == 16'h0000);
    end

endmodule

// File: rtl/hack_cpu_wide.sv
// rtl/hack_cpu_wide.sv - wide-fetch Hack core with A+C pair issue
// Optional perf counters enabled by HACK_CPU_WIDE_PERF_EN.
module hack_cpu_wide
    import hack_pkg::*;
#(
    parameter  int PC_WIDTH = 16,
    parameter  int LANES    = 2,
    localparam int LW       = $clog2(LANES)
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [16*LANES-1:0]    inst,
    input  logic [15:0]            in_m,
    output logic [PC_WIDTH-LW-1:0] inst_addr,
    output logic [14:0]            data_addr,
    output logic [15:0]            out_m,
    output logic                   write_m,
    output logic                   read_m
`ifdef HACK_CPU_WIDE_PERF_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_retired,
    output logic [31:0]            perf_dual
`endif
);

    logic [PC_WIDTH-1:0] r_pc, w_new_pc, w_target, w_inc;
    logic [15:0]         r_a, r_d;
    logic [15:0]         w_cur, w_nxt, w_ci, w_aop, w_y, w_alu;
    logic [LW-1:0]       w_slot, w_nslot;
    logic [14:0]         w_imm;
    logic                w_dual, w_is_c, w_zr, w_ng, w_gt, w_jmp;

    assign w_slot  = r_pc[LW-1:0];
    assign w_nslot = w_slot + 1'b1;
    assign w_cur   = inst[16*w_slot +: 16];
    assign w_nxt   = inst[16*w_nslot +: 16];
    assign w_imm   = w_cur[14:0];

    // An A-instruction in the last lane never pairs with the next word
    assign w_dual  = !w_cur[BIT_C] && (w_slot != LW'(LANES-1)) && w_nxt[BIT_C];
    assign w_ci    = w_dual ? w_nxt : w_cur;
    assign w_is_c  = w_ci[BIT_C];
    assign w_aop   = w_dual ? {1'b0, w_imm} : r_a;
    assign w_y     = w_ci[BIT_A] ? in_m : w_aop;

    hack_cpu_wide_alu u_alu (
        .x    (r_d),
        .y    (w_y),
        .fn   (alu_fn_t'(w_ci[COMP_LSB +: COMP_W])),
        .out  (w_alu),
        .zero (w_zr)
    );

    assign w_ng     = w_alu[15];
    assign w_gt     = !(w_zr || w_ng);
    assign w_jmp    = w_is_c && ((w_ci[JMP_LT] && w_ng) || (w_ci[JMP_EQ] && w_zr)
                                 || (w_ci[JMP_GT] && w_gt));
    assign w_target = w_dual ? PC_WIDTH'(w_imm) : PC_WIDTH'(r_a);
    assign w_inc    = w_dual ? PC_WIDTH'(2) : PC_WIDTH'(1);
    assign w_new_pc = w_jmp ? w_target : (r_pc + w_inc);

    assign inst_addr = (!stall && !reset) ? w_new_pc[PC_WIDTH-1:LW] : r_pc[PC_WIDTH-1:LW];
    assign data_addr = w_dual ? w_imm : r_a[14:0];
    assign out_m     = w_alu;
    assign write_m   = w_is_c && w_ci[DEST_M] && !stall && !reset;
    assign read_m    = w_is_c && w_ci[BIT_A];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
            r_a  <= '0;
            r_d  <= '0;
        end else if (!stall) begin
            r_pc <= w_new_pc;
            if (!w_is_c)
                r_a <= {1'b0, w_imm};
            else if (w_ci[DEST_A])
                r_a <= w_alu;
            else if (w_dual)
                r_a <= {1'b0, w_imm};
            if (w_is_c && w_ci[DEST_D])
                r_d <= w_alu;
        end
    end

`ifdef HACK_CPU_WIDE_PERF_EN
    logic [31:0] r_cycles, r_retired, r_dual;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycles  <= '0;
            r_retired <= '0;
            r_dual    <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (!stall) begin
                r_retired <= r_retired + (w_dual ? 32'd2 : 32'd1);
                if (w_dual)
                    r_dual <= r_dual + 32'd1;
            end
        end
    end

    assign perf_cycles  = r_cycles;
    assign perf_retired = r_retired;
    assign perf_dual    = r_dual;
`endif

endmodule

// File: doc/hack_cpu_wide.md
# hack_cpu_wide

Next-generation Hack CPU core with a parametrised fetch width: each instruction-ROM word carries LANES 16-bit Hack instructions. An A-instruction followed by a C-instruction in the same word issues as a pair in one cycle, with correct A-destination semantics. The core sits between the wide synchronous instruction ROM and the single-cycle data RAM, whose controller stalls the core. Optional performance counters expose cycle, retire and dual-issue counts.

## Interface

Parameters:
- PC_WIDTH, 16: instruction-index width; pc counts 16-bit instructions.
- LANES, 2: instructions per fetch word; legal values are 2 and 4. LW = log2(LANES).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  freeze request from the memory controller.
- inst  in  16*LANES  fetch word; lane k = inst[16k +: 16], lane 0 executes first.
- in_m  in  16  data RAM read data, valid in the same cycle as read_m.
- inst_addr  out  PC_WIDTH-LW  fetch-word address for the next cycle.
- data_addr  out  15  data RAM address.
- out_m  out  16  data RAM write data (ALU result).
- write_m  out  1  data RAM write strobe.
- read_m  out  1  asserted when the issuing C-instruction reads M (a-bit = 1).
- perf_cycles, perf_retired, perf_dual  out  32 each  present only with HACK_CPU_WIDE_PERF_EN.

## Operation

- State: pc[PC_WIDTH-1:0], A[15:0], D[15:0]. slot = pc[LW-1:0]; cur = lane slot of inst.
- Encoding: bit15 = 0 is an A-instruction (A <= {0, imm15}). bit15 = 1 is a C-instruction: a = bit12, comp = bits 11:6, dest = bits 5:3 (A, D, M), jump = bits 2:0 (LT, EQ, GT).
- Dual issue: cur is an A-instruction, slot < LANES-1, and lane slot+1 is a C-instruction. The C-instruction uses imm = cur[14:0] as its A operand, data_addr and jump target. Final A = ALU result if the C-instruction's dest includes A, else {0, imm}. pc increment is 2.
- Single issue: execute cur alone. pc increment is 1. An A-instruction in lane LANES-1 never pairs across words.
- ALU: x = D; y = in_m if a = 1, else A (or imm when dual-issued). The flags zr, ng and gt = !(zr | ng) select the jump.
- Jump target: {0, imm} zero-extended or truncated to PC_WIDTH on dual issue; A[PC_WIDTH-1:0] on single issue. Any slot is a legal target; execution starts mid-word.
- write_m = C-instruction with dest M, and !stall, and !reset. out_m = ALU result. data_addr = imm on dual issue, else A[14:0].
- new_pc = jump-taken ? target : pc + inc. This wraps modulo 2^PC_WIDTH.
- inst_addr = new_pc[PC_WIDTH-1:LW] when !stall and !reset; otherwise pc[PC_WIDTH-1:LW], so the ROM re-presents the current word.
- Stall: pc, A, D and the counters hold. Outputs stay combinationally valid, except write_m, which is 0.
- Reset: pc, A, D and the counters go to 0. Reset overrides stall.

## Timing

- Issue: one cycle per instruction or pair. inst for address X arrives the cycle after inst_addr = X.
- A taken jump costs no bubble, because new_pc is combinational into inst_addr.
- Reset values: inst_addr = 0; write_m = 0; out_m, data_addr and read_m follow A = D = 0 with inst as presented.
- A and D writes from the current cycle are visible to the next issue. The data RAM write commits at the same edge that updates A and D.
- Critical path: in_m -> ALU -> jump -> new_pc -> inst_addr. It is accepted because the RAM stalls when it is slow.

## Configuration

- HACK_CPU_WIDE_PERF_EN defined:
  - perf_cycles increments on every non-reset cycle.
  - perf_retired increments by 1 or 2 on every non-stalled, non-reset cycle.
  - perf_dual increments per dual-issued pair.
  - All three wrap at 2^32 and clear on reset.
- HACK_CPU_WIDE_PERF_EN undefined: the ports and counters are absent. The core is otherwise identical.

## Structure

- The package hack_pkg holds the bit-position constants (bit15, a, comp, dest and jump fields) and the ALU function typedef. The core and the bench share these.
- Sub-module: the existing alu (x, y, fn, out, zero), instantiated once.
- Lane selection, pairing detect and next-pc logic are inline.

## Test plan

- Reset: reset high for 3 cycles with stall = 1. Expect inst_addr = 0, write_m = 0, pc = A = D = 0 after release.
- Dual issue, LANES = 2: word {0xEC10 (D=A), 0x0005}. Expect D = 5 and A = 5 after 1 cycle, pc = 2, perf_dual = 1, perf_retired = 2.
- No cross-word pair, LANES = 4: @7 in lane 3, then D=A in lane 0 of the next word. Expect 2 cycles, D = 7, perf_dual unchanged.
- Dual-issue jump, LANES = 4: @10 then 0;JMP (0xEA87). Expect next inst_addr = 2, pc = 10, execution resumes at lane 2.
- Dual issue with A destination: @3 then AM=D+1 with D = 4. Expect A = 5 (not 3) and a write of 5 at data_addr 3.
- Stall: A = 100, D = 0x1234, M=D (0xE308) with stall high for 2 cycles. Expect write_m low for 2 cycles, then high for 1 cycle with data_addr = 100 and out_m = 0x1234. pc holds during the stall.
